fp_norm_pack: RTL and testbench

//  Output end of the float32 add/sub datapath: consumes BigALU's sign-magnitude result
//  (out, cout, sign_out) plus the common pre-aligned exponent, then renormalises it.

---
 rtl/fp_norm_pack_pkg.sv | 26 ++
 rtl/fp_norm_pack_if.sv | 33 +++
 rtl/fp_norm_pack_pack.sv | 33 +++
 rtl/fp_norm_pack.sv | 113 +++++++++++
 tb/tb_fp_norm_pack.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/fp_norm_pack_pkg.sv
// Shared float32 constants, FSM state encoding and result flags for the
// add/sub output stage.
package fp_norm_pack_pkg;

    localparam int EXP_W   = 8;
    localparam int MANT_W  = 24;
    localparam int FLOAT_W = 32;

    localparam logic [EXP_W-1:0]   EXP_MAX  = 8'hFF;
    localparam logic [FLOAT_W-1:0] POS_ZERO = 32'h0000_0000;
    localparam logic [FLOAT_W-1:0] POS_INF  = 32'h7F80_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    // At most one of these is set for any packed result.
    typedef struct packed {
        logic zero;
        logic underflow;
        logic overflow;
    } flags_t;

endpackage

// File: rtl/fp_norm_pack_if.sv
// Input (ALU result) and output (packed float) handshake channels.
interface fp_norm_pack_if
    import fp_norm_pack_pkg::*;
#(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [MANT_W-1:0] in_mant;
    logic              in_cout;
    logic              in_sign;
    logic [EXP_W-1:0]  in_exp;

    logic               out_valid;
    logic               out_ready;
    logic [FLOAT_W-1:0] out_float;
    logic               out_zero;
    logic               out_underflow;
    logic               out_overflow;

    // Producer of ALU results / consumer of packed floats.
    modport master (
        output in_valid, in_mant, in_cout, in_sign, in_exp, out_ready,
        input  in_ready, out_valid, out_float, out_zero, out_underflow, out_overflow
    );

    // The normaliser itself.
    modport slave (
        input  in_valid, in_mant, in_cout, in_sign, in_exp, out_ready,
        output in_ready, out_valid, out_float, out_zero, out_underflow, out_overflow
    );
endinterface

// File: rtl/fp_norm_pack_pack.sv
// Combinational packer: {sign, exp_r, mant_r} -> IEEE754 single plus flags.
// Overflow beats zero beats normal/subnormal packing.
module fp_pack
    import fp_norm_pack_pkg::*;
(
    input  logic               sign,
    input  logic [EXP_W:0]     exp_r,
    input  logic [MANT_W-1:0]  mant_r,
    output logic [FLOAT_W-1:0] float_o,
    output flags_t             flags
);
    logic [EXP_W-1:0] exp_field;

    // Select the packed word and the single flag that describes it.
    always_comb begin
        float_o   = POS_ZERO;
        flags     = '0;
        exp_field = '0;
        if (exp_r >= {1'b0, EXP_MAX}) begin
            float_o        = {sign, EXP_MAX, {(MANT_W-1){1'b0}}};
            flags.overflow = 1'b1;
        end else if (mant_r == '0) begin
            // Exact cancellation always gives +0, whatever the ALU sign.
            float_o    = POS_ZERO;
            flags.zero = 1'b1;
        end else begin
            // Without the hidden bit the normaliser stopped at exp 1: subnormal.
            exp_field       = mant_r[MANT_W-1] ? exp_r[EXP_W-1:0] : '0;
            float_o         = {sign, exp_field, mant_r[MANT_W-2:0]};
            flags.underflow = (exp_field == '0);
        end
    end
endmodule

// File: rtl/fp_norm_pack.sv
// Output end of the float32 add/sub datapath. Takes the ALU sign-magnitude
// result and the pre-aligned exponent, renormalises it one left shift per
// cycle, then packs an IEEE754 single (truncating rounding).
module fp_norm_pack
    import fp_norm_pack_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    fp_norm_pack_if.slave bus
);
    localparam logic [EXP_W:0] EXP_ONE = {{EXP_W{1'b0}}, 1'b1};

    state_t             state, state_nxt;
    logic [MANT_W-1:0]  mant_r;
    logic [EXP_W:0]     exp_r;      // one spare bit so the carry increment cannot wrap
    logic               sign_r;
    logic [FLOAT_W-1:0] float_r;
    flags_t             flags_r;
    logic               valid_r;

    logic [EXP_W:0]     e_eff;
    logic               norm_stop;
    logic               accept;
    logic               handshake;
    logic [FLOAT_W-1:0] pack_float;
    flags_t             pack_flags;

    // Subnormal operands (exp 0) are aligned as if their exponent were 1.
    assign e_eff     = (bus.in_exp == '0) ? EXP_ONE : {1'b0, bus.in_exp};
    assign accept    = (state == IDLE) && bus.in_valid;
    assign handshake = valid_r && bus.out_ready;

    // Shifting ends on overflow, zero, hidden bit reached, or minimum exponent.
    assign norm_stop = (exp_r >= {1'b0, EXP_MAX}) || (mant_r == '0) ||
                       mant_r[MANT_W-1] || (exp_r == EXP_ONE);

    fp_pack u_pack (
        .sign    (sign_r),
        .exp_r   (exp_r),
        .mant_r  (mant_r),
        .float_o (pack_float),
        .flags   (pack_flags)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: IDLE -> NORM on accept, NORM -> DONE when normalised,
    // DONE -> IDLE once the result has been taken.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = NORM;
            NORM:    if (norm_stop)    state_nxt = DONE;
            DONE:    if (handshake)    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: load/pre-shift on accept, one normalising shift per NORM cycle,
    // capture the packed word on NORM exit. out_valid is raised on the cycle after
    // capture, so the result is presented from a settled register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mant_r  <= '0;
            exp_r   <= '0;
            sign_r  <= 1'b0;
            float_r <= POS_ZERO;
            flags_r <= '0;
            valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sign_r  <= bus.in_sign;
                        flags_r <= '0;
                        if (bus.in_cout) begin
                            mant_r <= {1'b1, bus.in_mant[MANT_W-1:1]};
                            exp_r  <= e_eff + EXP_ONE;
                        end else begin
                            mant_r <= bus.in_mant;
                            exp_r  <= e_eff;
                        end
                    end
                end
                NORM: begin
                    if (norm_stop) begin
                        float_r <= pack_float;
                        flags_r <= pack_flags;
                    end else begin
                        mant_r <= {mant_r[MANT_W-2:0], 1'b0};
                        exp_r  <= exp_r - EXP_ONE;
                    end
                end
                DONE: begin
                    if (!valid_r)      valid_r <= 1'b1;
                    else if (handshake) valid_r <= 1'b0;
                end
                default: valid_r <= 1'b0;
            endcase
        end
    end

    assign bus.in_ready      = (state == IDLE);
    assign bus.out_valid     = valid_r;
    assign bus.out_float     = float_r;
    assign bus.out_zero      = flags_r.zero;
    assign bus.out_underflow = flags_r.underflow;
    assign bus.out_overflow  = flags_r.overflow;
endmodule

// File: tb/tb_fp_norm_pack.sv
// Scoreboard bench for fp_norm_pack: the driver pushes hand-computed results,
// a negedge monitor pops and compares on every output handshake.
module tb_fp_norm_pack;
    import fp_norm_pack_pkg::*;

    typedef struct {
        logic [31:0] f;
        logic [2:0]  flg;   // {zero, underflow, overflow}
        int          lat;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t sb[$];
    bit   prev_v = 1'b0;
    int   rise = 0;

    fp_norm_pack_if bus ();

    fp_norm_pack dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, req);
        end
    endtask

    // Monitor: compares every accepted output against the scoreboard head.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (bus.out_valid && !prev_v) rise = cyc;
            prev_v = bus.out_valid;
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", bus.out_float, 32'hxxxx_xxxx);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("float", bus.out_float, e.f);
                    chk("flags", {29'd0, bus.out_zero, bus.out_underflow, bus.out_overflow},
                        {29'd0, e.flg});
                    chk("latency", rise - e.acc, e.lat);
                end
            end
        end
    end

    task automatic send(input logic [23:0] m, input logic c, input logic [7:0] e,
                        input logic s, input logic [31:0] f, input logic [2:0] flg,
                        input int k, input bit push);
        int w = 0;
        @(posedge clk); #1;
        while (!bus.in_ready && w < 300) begin
            @(posedge clk); #1;
            w++;
        end
        if (!bus.in_ready) begin
            chk("accept_timeout", {31'd0, bus.in_ready}, 32'd1);
            return;
        end
        bus.in_mant  = m;
        bus.in_cout  = c;
        bus.in_exp   = e;
        bus.in_sign  = s;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        if (push) sb.push_back('{f: f, flg: flg, lat: 2 + k, acc: cyc});
    endtask

    task automatic drain();
        int w = 0;
        while (sb.size() != 0 && w < 300) begin
            @(posedge clk); #1;
            w++;
        end
        chk("drain_left", sb.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        int seen;
        bus.in_valid  = 1'b0;
        bus.in_mant   = '0;
        bus.in_cout   = 1'b0;
        bus.in_sign   = 1'b0;
        bus.in_exp    = '0;
        bus.out_ready = 1'b1;
        #12;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_float", bus.out_float, 32'd0);
        chk("rst_flags", {29'd0, bus.out_zero, bus.out_underflow, bus.out_overflow}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        //      mant        cout  exp    sign  expected       {z,u,o} k
        send(24'h800000, 1'b0, 8'd127, 1'b0, 32'h3F800000, 3'b000, 0,  1'b1);
        send(24'h000000, 1'b1, 8'd127, 1'b0, 32'h40000000, 3'b000, 0,  1'b1);
        send(24'h000001, 1'b0, 8'd127, 1'b1, 32'hB4000000, 3'b000, 23, 1'b1);
        send(24'h000100, 1'b0, 8'd3,   1'b0, 32'h00000400, 3'b010, 2,  1'b1);
        send(24'hFFFFFE, 1'b1, 8'd254, 1'b0, 32'h7F800000, 3'b001, 0,  1'b1);
        send(24'h000000, 1'b0, 8'd100, 1'b1, 32'h00000000, 3'b100, 0,  1'b1);
        send(24'h000400, 1'b0, 8'd0,   1'b0, 32'h00000400, 3'b010, 0,  1'b1);
        send(24'h800000, 1'b0, 8'd0,   1'b0, 32'h00800000, 3'b000, 0,  1'b1);
        send(24'h000002, 1'b1, 8'd0,   1'b0, 32'h01000001, 3'b000, 0,  1'b1);
        send(24'hFFFFFF, 1'b0, 8'd254, 1'b1, 32'hFF7FFFFF, 3'b000, 0,  1'b1);
        send(24'h00F000, 1'b0, 8'd20,  1'b0, 32'h06700000, 3'b000, 8,  1'b1);
        drain();

        // Back-pressure: result must hold while out_ready is low.
        bus.out_ready = 1'b0;
        send(24'h800000, 1'b0, 8'd127, 1'b0, 32'h3F800000, 3'b000, 0, 1'b1);
        w = 0;
        while (!bus.out_valid && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("stall_float", bus.out_float, 32'h3F800000);
            chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        drain();

        // Reset in the middle of a long normalisation drops the result.
        send(24'h000001, 1'b0, 8'd127, 1'b1, 32'hB4000000, 3'b000, 23, 1'b0);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        chk("midrst_no_output", seen, 32'd0);

        send(24'h000000, 1'b1, 8'd127, 1'b0, 32'h40000000, 3'b000, 0, 1'b1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
